// File: rtl/peripheral_axi4_burst_addr_gen_pkg.sv
// peripheral_axi4_burst_addr_gen_pkg: shared AXI4 constants, command type and burst helpers
package peripheral_axi4_burst_addr_gen_pkg;
  localparam int AXI_ID_WIDTH = 10;
  localparam int AXI_ADDR_WIDTH = 64;
  localparam int AXI_LEN_WIDTH = 8;
  localparam int AXI_4KB_BOUNDARY = 4096;
  localparam int AXI_4KB_SHIFT = $clog2(AXI_4KB_BOUNDARY);
  localparam logic [3:0][7:0] AXI_WRAP_LEN = {8'd15, 8'd7, 8'd3, 8'd1};
  localparam logic [1:0] AXI_RESPONSE_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESPONSE_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESPONSE_SLAVE_ERROR = 2'b10;
  localparam logic [1:0] AXI_RESPONSE_DECODE_ERROR = 2'b11;
  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_t;
  typedef enum logic {
    S_IDLE,
    S_BURST
  } burst_state_t;
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_LEN_WIDTH-1:0]  len;
    logic [2:0]                size;
    logic [1:0]                burst;
  } axi4_cmd_t;
  function automatic logic axi_wrap_len_ok(input int unsigned len);
    axi_wrap_len_ok = 1'b0;
    for (int i = 0; i < 4; i++)
      if (len == 32'(AXI_WRAP_LEN[i])) axi_wrap_len_ok = 1'b1;
  endfunction
endpackage

// File: rtl/peripheral_axi4_burst_next_addr.sv
// peripheral_axi4_burst_next_addr: combinational next-beat address for FIXED, INCR and WRAP bursts
module peripheral_axi4_burst_next_addr
  import peripheral_axi4_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic [ADDR_WIDTH-1:0] i_cur,
  input  logic [2:0]            i_size,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next
);
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;
  logic [ADDR_WIDTH-1:0] w_b, w_t, w_base, w_inc, w_aligned_inc;
  assign w_b = ONE << i_size;
  assign w_t = (ADDR_WIDTH'(i_len) + ONE) << i_size;
  assign w_base = i_cur & ~(w_t - ONE);
  assign w_inc = i_cur + w_b;
  // INCR realigns after the first beat so an unaligned start lands on the next size boundary
  assign w_aligned_inc = (i_cur & ~(w_b - ONE)) + w_b;
  always_comb
    o_next = i_burst == AXI_BURST_FIXED ? i_cur :
             i_burst == AXI_BURST_WRAP  ? (w_inc == w_base + w_t ? w_base : w_inc) :
             w_aligned_inc;
endmodule

// File: rtl/peripheral_axi4_burst_addr_gen.sv
// peripheral_axi4_burst_addr_gen: AXI4 burst beat sequencer emitting per-beat address, lane, last and error
module peripheral_axi4_burst_addr_gen
  import peripheral_axi4_burst_addr_gen_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_LEN_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXI_LEN_WIDTH-1:0]  cmd_len,
  input  logic [2:0]                cmd_size,
  input  logic [1:0]                cmd_burst,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic [AXI_ID_WIDTH-1:0]   beat_id,
  output logic [AXI_ADDR_WIDTH-1:0] beat_addr,
  output logic [(AXI_DATA_WIDTH > 8 ? $clog2(AXI_DATA_WIDTH / 8) : 1)-1:0] beat_lane,
  output logic                      beat_last,
  output logic                      beat_err,
  output logic                      busy
);
  localparam int LANE_W = $clog2(AXI_DATA_WIDTH / 8);
  localparam int LW = LANE_W > 0 ? LANE_W : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] ONE = 1;
  burst_state_t r_state;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, w_next, w_bmask, w_end;
  logic [AXI_LEN_WIDTH-1:0] r_len;
  logic [AXI_LEN_WIDTH:0] r_cnt;
  logic [2:0] r_size;
  logic [1:0] r_burst;
  logic r_err, w_err, w_accept, w_hs, w_last;
  peripheral_axi4_burst_next_addr #(
    .ADDR_WIDTH(AXI_ADDR_WIDTH),
    .LEN_WIDTH (AXI_LEN_WIDTH)
  ) u_next_addr (
    .i_cur  (r_addr),
    .i_size (r_size),
    .i_len  (r_len),
    .i_burst(r_burst),
    .o_next (w_next)
  );
  assign beat_valid = r_state == S_BURST;
  assign busy = beat_valid;
  assign beat_id = r_id;
  assign beat_addr = r_addr;
  assign beat_lane = LANE_W == 0 ? '0 : r_addr[LW-1:0];
  assign w_last = r_cnt == {1'b0, r_len};
  assign beat_last = beat_valid & w_last;
  assign beat_err = beat_valid & r_err;
  assign w_hs = beat_valid & beat_ready;
  // combinational from beat_ready so a new command can follow the last beat without a bubble
  assign cmd_ready = (r_state == S_IDLE) | (w_hs & w_last);
  assign w_accept = cmd_valid & cmd_ready;
  assign w_bmask = (ONE << cmd_size) - ONE;
  assign w_end = (cmd_addr & ~w_bmask) + (AXI_ADDR_WIDTH'(cmd_len) << cmd_size);
  assign w_err = (cmd_burst == AXI_BURST_RSVD) ||
                 (int'(cmd_size) > LANE_W) ||
                 (cmd_burst == AXI_BURST_WRAP && (!axi_wrap_len_ok(32'(cmd_len)) || |(cmd_addr & w_bmask))) ||
                 (cmd_burst == AXI_BURST_FIXED && 32'(cmd_len) > 32'd15) ||
                 (cmd_burst == AXI_BURST_INCR &&
                  w_end[AXI_ADDR_WIDTH-1:AXI_4KB_SHIFT] != cmd_addr[AXI_ADDR_WIDTH-1:AXI_4KB_SHIFT]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_BURST;
      r_id <= cmd_id;
      r_addr <= cmd_addr;
      r_len <= cmd_len;
      r_cnt <= '0;
      r_size <= cmd_size;
      r_burst <= cmd_burst;
      r_err <= w_err;
    end else if (w_hs && w_last) begin
      r_state <= S_IDLE;
    end else if (w_hs) begin
      r_addr <= w_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: doc/peripheral_axi4_burst_addr_gen.md
Name: peripheral_axi4_burst_addr_gen

Overview:
- Parametrised AXI4 burst beat sequencer for AXI4 slave peripherals on the NoC.
- Accepts one AW/AR-style command and emits one per-beat record per data transfer: address, byte lane, last flag and error flag.
- Supports FIXED, INCR and WRAP bursts, AXI4 lengths up to 256 beats, and any size up to the data width.
- Shared by the read and write data paths of peripheral slaves.

Parameters:
- AXI_ID_WIDTH, 10, transaction ID width.
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data bus width in bits; power of 2, range 8..1024.
- AXI_LEN_WIDTH, 8, burst length field width; 4 gives AXI3 behaviour.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- cmd_valid, in, 1, command valid.
- cmd_ready, out, 1, command accepted when high together with cmd_valid.
- cmd_id, in, AXI_ID_WIDTH, transaction ID.
- cmd_addr, in, AXI_ADDR_WIDTH, start address.
- cmd_len, in, AXI_LEN_WIDTH, beats minus 1.
- cmd_size, in, 3, log2 bytes per beat.
- cmd_burst, in, 2, burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- beat_valid, out, 1, beat record valid.
- beat_ready, in, 1, downstream accepts beat.
- beat_id, out, AXI_ID_WIDTH, ID of the current burst.
- beat_addr, out, AXI_ADDR_WIDTH, beat address.
- beat_lane, out, log2(AXI_DATA_WIDTH/8), byte offset of beat_addr within the data word.
- beat_last, out, 1, final beat of the burst.
- beat_err, out, 1, burst illegal; downstream answers SLVERR.
- busy, out, 1, burst in progress.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all outputs 0, except cmd_ready=1. State goes to IDLE.
- Reset mid-burst: the burst is discarded immediately and no further beats are emitted.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command, compute the error flag and go to BURST. The first beat is valid the next cycle (latency 1).
  - BURST: beat_valid=1. On a beat handshake with beat_last=1, return to IDLE.
- Back-to-back bursts: cmd_ready = IDLE or (beat_valid and beat_ready and beat_last). This path is combinational from beat_ready.
  - A command accepted on the last-beat handshake starts its first beat the following cycle with no bubble.
- Backpressure: while beat_valid=1 and beat_ready=0, all beat_* outputs hold stable.
- Beat counter: AXI_LEN_WIDTH+1 bits, counts 0..cmd_len. beat_last = (count == len). len=0 gives a single beat with last=1.
- Address arithmetic, with B = 1<<size and A = addr & ~(B-1):
  - FIXED: every beat uses addr.
  - INCR: beat 0 uses addr (unaligned allowed). Beat n≥1 uses A + n*B, modulo 2^AXI_ADDR_WIDTH.
  - WRAP: T = B*(len+1) and base = addr & ~(T-1). Next = cur+B; if next == base+T, next = base. Start address must be B-aligned.
- beat_lane = beat_addr[log2(DATA_BYTES)-1:0].
- beat_err is computed at acceptance and held for the whole burst. The burst still emits len+1 beats so every beat gets a response. Error conditions:
  - cmd_burst = 11;
  - B > AXI_DATA_WIDTH/8;
  - WRAP with len not in {1,3,7,15};
  - WRAP with start address not B-aligned;
  - FIXED with len > 15;
  - INCR where the last beat address crosses a 4 KB boundary relative to addr, i.e. (A + len*B)[AXI_ADDR_WIDTH-1:12] ≠ addr[AXI_ADDR_WIDTH-1:12].
- Simultaneous events: rst overrides everything. A new command offered while BURST has beat_ready=0 or is not on its last beat is not accepted.

Decomposition:
- Shared package gains:
  - AXI_LEN_WIDTH;
  - AXI_4KB_BOUNDARY = 4096;
  - AXI_WRAP_LEN set;
  - a correction of AXI_RESPONSE_DECODE_ERROR to 2'b11;
  - a typedef struct for the command (id, addr, len, size, burst).
- Sub-module peripheral_axi4_burst_next_addr: combinational next-address and wrap logic taking cur, size, len and burst. Reused by DMA and the bridges.

Test Plan:
- INCR, addr=0x1004, size=3, len=3 -> beat_addr 0x1004, 0x1008, 0x1010, 0x1018; lanes 4,0,0,0; last on beat 4; err=0.
- WRAP, addr=0x38, size=2, len=3 -> 0x38, 0x3C, 0x30, 0x34; last on beat 4; err=0. WRAP with len=2 -> 3 beats, err=1.
- FIXED, addr=0x100, size=2, len=2 -> 0x100 ×3. cmd_burst=11, len=1 -> 2 beats, err=1.
- INCR, addr=0xFF8, size=3, len=1 -> beats 0xFF8, 0x1000, err=1. size=4 on 64-bit bus -> err=1.
- Backpressure: toggle beat_ready randomly -> outputs stable while stalled. Back-to-back commands -> cmd_ready=1 on the last handshake and the next burst's first beat arrives the following cycle.
- Assert rst asynchronously mid-burst, beat 2 of 8 -> beat_valid=0 and cmd_ready=1 immediately; the next command starts cleanly.
